mvm_uart_ctrl: RTL and testbench
================================

Name: mvm_uart_ctrl

Overview:
Frame controller between the UART receiver/transmitter and the matrix-vector multiply core inside the UART MVM system. It deserialises N_WORDS_KX received bytes into the packed K/X operand bus and issues a one-cycle start to the MVM core. It captures the Y result on done and serialises it as N_WORDS_Y bytes to the UART TX over a valid/ready handshake. It also discards stale partial frames on an inter-byte timeout and flags bytes dropped while busy.

Parameters:
R, 2, matrix rows
C, 2, matrix columns / vector length
W_X, 4, signed X element width
W_K, 4, signed K element width
W_Y_OUT, 8, per-row output width sent over UART
BITS_PER_WORD, 8, UART byte width
TIMEOUT_CYCLES, 10000, idle cycles after the last byte before a partial frame is discarded; 0 disables
W_BUS_KX (derived), R*C*W_K + C*W_X; must be a multiple of BITS_PER_WORD
W_BUS_Y (derived), R*W_Y_OUT; must be a multiple of BITS_PER_WORD
N_WORDS_KX, N_WORDS_Y (derived), bus width / BITS_PER_WORD

Ports:
clk  in  1  clock
rstn  in  1  asynchronous active-low reset
rx_valid  in  1  one-cycle strobe, received byte valid; no backpressure
rx_data  in  BITS_PER_WORD  received byte
mvm_kx  out  W_BUS_KX  packed {K[R-1..0][C-1..0], X[C-1..0]}, X in LSBs
mvm_start  out  1  one-cycle start pulse to the MVM core
mvm_done  in  1  one-cycle strobe, mvm_y valid
mvm_y  in  W_BUS_Y  packed Y[R-1..0], row 0 in LSBs
tx_valid  out  1  byte offered to the UART TX
tx_data  out  BITS_PER_WORD  byte to transmit
tx_ready  in  1  UART TX accepts the byte when tx_valid && tx_ready
busy  out  1  high in any state other than RECV
overrun  out  1  sticky; a byte was dropped
timeout_err  out  1  sticky; a partial frame was discarded

Behaviour:
- Reset (asynchronous) values: state RECV; all counters 0; mvm_kx 0; Y register 0; mvm_start 0; tx_valid 0; tx_data 0; busy 0; overrun 0; timeout_err 0. Sticky flags clear only on reset.
- All outputs are registered or decoded from registered state. No combinational path from any input to any output.
- State RECV:
  - When rx_valid is high, write rx_data into byte slot rx_cnt of mvm_kx. Byte 0 occupies bits [7:0], so the first byte received is the LSB byte. Clear the idle counter.
  - If rx_cnt == N_WORDS_KX-1, set rx_cnt to 0 and go to START. Otherwise increment rx_cnt.
  - When rx_cnt > 0 and rx_valid is low, increment the idle counter.
  - When the idle counter reaches TIMEOUT_CYCLES-1: set rx_cnt to 0, set timeout_err, clear the idle counter. mvm_kx keeps its contents.
  - If rx_valid arrives in the same cycle as the timeout would expire, the byte is accepted and no timeout occurs.
- State START: mvm_start is high for exactly this one cycle, then go to WAIT. If the last byte is accepted in cycle t, mvm_start is high in cycle t+1.
- State WAIT: when mvm_done is high, latch mvm_y, set tx_idx to 0, go to SEND. mvm_done is ignored in every other state.
- State SEND:
  - tx_valid = 1; tx_data = byte tx_idx of the Y register, byte 0 (LSBs) first.
  - On tx_valid && tx_ready: if tx_idx == N_WORDS_Y-1, go to RECV and drop tx_valid in the next cycle. Otherwise increment tx_idx.
  - tx_data stays stable while tx_valid is high and tx_ready is low.
- mvm_kx stays stable from START until the first byte of the next frame.
- rx_valid in START, WAIT or SEND: the byte is dropped, overrun is set, and the frame counter is unaffected.
- Reset asserted mid-frame, mid-compute or mid-send returns all state to the reset values immediately. A late mvm_done after reset is ignored because the state is RECV.
- No arithmetic is performed here. Widths are checked by elaboration-time assertions on both multiple-of-BITS_PER_WORD rules.

Decomposition:
- Shared package mvm_uart_pkg holds:
  - the state enum (RECV, START, WAIT, SEND);
  - the derived localparams W_Y, W_BUS_KX, W_BUS_Y, N_WORDS_KX, N_WORDS_Y, computed from the same parameter set used by the system top and the testbench.
- One sub-module is natural: mvm_frame_timer, holding the idle counter with clear/enable inputs and an expire output, so the timeout can be tested in isolation.

Test Plan:
- Receive bytes 0x21, 0x43, 0x65 → mvm_kx = 0x654321 (x = {2,1}, K rows {4,3} and {6,5}); mvm_start is high exactly one cycle, at t+1 after the last byte.
- Model returns mvm_done with mvm_y = 0x110B (y0 = 3*1 + 4*2 = 11, y1 = 5*1 + 6*2 = 17) → tx bytes 0x0B then 0x11; busy falls the cycle after the second handshake.
- Hold tx_ready low for 5 cycles in SEND → tx_valid stays 1 and tx_data stays 0x0B; no byte is skipped or repeated.
- With TIMEOUT_CYCLES = 20, send one byte 0xAA and stay idle 25 cycles → timeout_err = 1, rx_cnt = 0; the next three bytes form a fresh frame and produce a single mvm_start.
- Send a byte during WAIT → overrun = 1, no state change; the frame still completes with correct Y.
- Drop rstn during SEND after the first tx byte → all outputs return to reset values; a new frame then runs cleanly end to end.

Source files
------------

// File: rtl/mvm_uart_pkg.sv
// Shared parameter set and FSM encoding for the UART-to-MVM frame controller.
package mvm_uart_pkg;

    localparam int R             = 2;
    localparam int C             = 2;
    localparam int W_X           = 4;
    localparam int W_K           = 4;
    localparam int W_Y_OUT       = 8;
    localparam int BITS_PER_WORD = 8;

    localparam int W_Y        = W_X + W_K + $clog2(C);
    localparam int W_BUS_KX   = R * C * W_K + C * W_X;
    localparam int W_BUS_Y    = R * W_Y_OUT;
    localparam int N_WORDS_KX = W_BUS_KX / BITS_PER_WORD;
    localparam int N_WORDS_Y  = W_BUS_Y / BITS_PER_WORD;

    typedef enum logic [1:0] {
        RECV  = 2'd0,
        START = 2'd1,
        WAIT  = 2'd2,
        SEND  = 2'd3
    } state_t;

endpackage

// File: rtl/mvm_frame_timer.sv
// Inter-byte idle counter; expires after TIMEOUT_CYCLES enabled cycles.
module mvm_frame_timer #(
    parameter int TIMEOUT_CYCLES = 10000
) (
    input  logic clk,
    input  logic rstn,
    input  logic i_clr,
    input  logic i_en,
    output logic o_expire
);

    localparam int W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [W-1:0] LAST = W'(TIMEOUT_CYCLES - 1);

    logic [W-1:0] r_cnt;

    // A zero budget disables the timeout entirely.
    if (TIMEOUT_CYCLES == 0) begin : g_off
        assign o_expire = 1'b0;
    end else begin : g_on
        assign o_expire = i_en && (r_cnt == LAST);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_cnt <= '0;
        end else if (i_clr || o_expire) begin
            r_cnt <= '0;
        end else if (i_en) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/mvm_uart_ctrl.sv
// Frame controller: bytes in -> K/X bus + start, Y result -> bytes out.
module mvm_uart_ctrl
    import mvm_uart_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 10000
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic                     rx_valid,
    input  logic [BITS_PER_WORD-1:0] rx_data,
    output logic [W_BUS_KX-1:0]      mvm_kx,
    output logic                     mvm_start,
    input  logic                     mvm_done,
    input  logic [W_BUS_Y-1:0]       mvm_y,
    output logic                     tx_valid,
    output logic [BITS_PER_WORD-1:0] tx_data,
    input  logic                     tx_ready,
    output logic                     busy,
    output logic                     overrun,
    output logic                     timeout_err
);

    localparam int RXW = (N_WORDS_KX > 1) ? $clog2(N_WORDS_KX) : 1;
    localparam int TXW = (N_WORDS_Y > 1) ? $clog2(N_WORDS_Y) : 1;
    localparam logic [RXW-1:0] RX_LAST = RXW'(N_WORDS_KX - 1);
    localparam logic [TXW-1:0] TX_LAST = TXW'(N_WORDS_Y - 1);

    if ((W_BUS_KX % BITS_PER_WORD) != 0) begin : g_bad_kx
        $error("W_BUS_KX is not a multiple of BITS_PER_WORD");
    end
    if ((W_BUS_Y % BITS_PER_WORD) != 0) begin : g_bad_y
        $error("W_BUS_Y is not a multiple of BITS_PER_WORD");
    end

    state_t                r_state;
    state_t                w_next;
    logic [RXW-1:0]        r_rx_cnt;
    logic [TXW-1:0]        r_tx_idx;
    logic [W_BUS_KX-1:0]   r_kx;
    logic [W_BUS_Y-1:0]    r_y;
    logic                  r_overrun;
    logic                  r_timeout;
    logic                  w_idle_en;
    logic                  w_expire;
    logic                  w_rx_last;
    logic                  w_tx_fire;

    assign w_rx_last = (r_rx_cnt == RX_LAST);
    assign w_tx_fire = (r_state == SEND) && tx_ready;
    assign w_idle_en = (r_state == RECV) && (r_rx_cnt != '0) && !rx_valid;

    mvm_frame_timer #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timer (
        .clk     (clk),
        .rstn    (rstn),
        .i_clr   (rx_valid),
        .i_en    (w_idle_en),
        .o_expire(w_expire)
    );

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state <= RECV;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            RECV:  if (rx_valid && w_rx_last) w_next = START;
            START: w_next = WAIT;
            WAIT:  if (mvm_done) w_next = SEND;
            SEND:  if (tx_ready && r_tx_idx == TX_LAST) w_next = RECV;
            default: w_next = RECV;
        endcase
    end

    always_comb begin
        mvm_start   = (r_state == START);
        busy        = (r_state != RECV);
        tx_valid    = (r_state == SEND);
        tx_data     = r_y[r_tx_idx*BITS_PER_WORD +: BITS_PER_WORD];
        mvm_kx      = r_kx;
        overrun     = r_overrun;
        timeout_err = r_timeout;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_rx_cnt  <= '0;
            r_tx_idx  <= '0;
            r_kx      <= '0;
            r_y       <= '0;
            r_overrun <= 1'b0;
            r_timeout <= 1'b0;
        end else begin
            if (r_state == RECV) begin
                if (rx_valid) begin
                    r_kx[r_rx_cnt*BITS_PER_WORD +: BITS_PER_WORD] <= rx_data;
                    r_rx_cnt <= w_rx_last ? '0 : r_rx_cnt + 1'b1;
                end else if (w_expire) begin
                    // Stale partial frame: restart slot count, keep old bus.
                    r_rx_cnt  <= '0;
                    r_timeout <= 1'b1;
                end
            end else if (rx_valid) begin
                r_overrun <= 1'b1;
            end
            if (r_state == WAIT && mvm_done) begin
                r_y      <= mvm_y;
                r_tx_idx <= '0;
            end
            if (w_tx_fire) begin
                r_tx_idx <= (r_tx_idx == TX_LAST) ? '0 : r_tx_idx + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_mvm_uart_ctrl.sv
// Randomised frame bench with a behavioural matrix-vector reference.
module tb_mvm_uart_ctrl;
    import mvm_uart_pkg::*;

    localparam int TO = 20;

    logic                     clk = 1'b0;
    logic                     rstn = 1'b0;
    logic                     rx_valid = 1'b0;
    logic [BITS_PER_WORD-1:0] rx_data = '0;
    logic [W_BUS_KX-1:0]      mvm_kx;
    logic                     mvm_start;
    logic                     mvm_done = 1'b0;
    logic [W_BUS_Y-1:0]       mvm_y = '0;
    logic                     tx_valid;
    logic [BITS_PER_WORD-1:0] tx_data;
    logic                     tx_ready = 1'b0;
    logic                     busy;
    logic                     overrun;
    logic                     timeout_err;

    int n_chk = 0;
    int n_fail = 0;
    int n_starts = 0;
    int exp_starts = 0;
    bit exp_ovr = 1'b0;
    bit exp_to = 1'b0;

    mvm_uart_ctrl #(.TIMEOUT_CYCLES(TO)) dut (
        .clk        (clk),
        .rstn       (rstn),
        .rx_valid   (rx_valid),
        .rx_data    (rx_data),
        .mvm_kx     (mvm_kx),
        .mvm_start  (mvm_start),
        .mvm_done   (mvm_done),
        .mvm_y      (mvm_y),
        .tx_valid   (tx_valid),
        .tx_data    (tx_data),
        .tx_ready   (tx_ready),
        .busy       (busy),
        .overrun    (overrun),
        .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (mvm_start) n_starts++;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [W_BUS_Y-1:0] ref_y(input logic [W_BUS_KX-1:0] kx);
        logic [W_BUS_Y-1:0] y;
        logic signed [W_K-1:0] k;
        logic signed [W_X-1:0] x;
        logic signed [31:0] acc;
        y = '0;
        for (int i = 0; i < R; i++) begin
            acc = 0;
            for (int j = 0; j < C; j++) begin
                x = kx[j*W_X +: W_X];
                k = kx[C*W_X + (i*C + j)*W_K +: W_K];
                acc = acc + k * x;
            end
            y[i*W_Y_OUT +: W_Y_OUT] = acc[W_Y_OUT-1:0];
        end
        return y;
    endfunction

    task automatic send_byte(input logic [7:0] b);
        rx_valid = 1'b1;
        rx_data  = b;
        step();
        rx_valid = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_kx"}, mvm_kx, '0);
        check({tag, "_start"}, mvm_start, 0);
        check({tag, "_txv"}, tx_valid, 0);
        check({tag, "_txd"}, tx_data, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_ovr"}, overrun, 0);
        check({tag, "_to"}, timeout_err, 0);
    endtask

    task automatic run_frame(input bit fixed, input bit inject,
                             input bit rst_mid, input int stall0);
        logic [W_BUS_KX-1:0] kx_exp;
        logic [W_BUS_Y-1:0]  y_exp;
        logic [7:0]          eb;
        int                  st;
        if (fixed) kx_exp = W_BUS_KX'(24'h654321);
        else for (int i = 0; i < N_WORDS_KX; i++) kx_exp[i*8 +: 8] = 8'($urandom);
        for (int i = 0; i < N_WORDS_KX; i++) begin
            if (i > 0) repeat ($urandom_range(0, 8)) step();
            check("busy_recv", busy, 0);
            send_byte(kx_exp[i*8 +: 8]);
        end
        exp_starts++;
        check("start_pulse", mvm_start, 1);
        check("kx", mvm_kx, kx_exp);
        check("busy_start", busy, 1);
        step();
        check("start_once", mvm_start, 0);
        y_exp = ref_y(kx_exp);
        repeat ($urandom_range(0, 5)) step();
        if (inject) begin
            send_byte(8'($urandom));
            exp_ovr = 1'b1;
            check("ovr_set", overrun, 1);
            check("ovr_busy", busy, 1);
            check("ovr_txv", tx_valid, 0);
        end
        mvm_done = 1'b1;
        mvm_y    = y_exp;
        step();
        mvm_done = 1'b0;
        mvm_y    = W_BUS_Y'($urandom);
        check("kx_hold", mvm_kx, kx_exp);
        for (int k = 0; k < N_WORDS_Y; k++) begin
            eb = y_exp[k*8 +: 8];
            st = (k == 0 && stall0 >= 0) ? stall0 : $urandom_range(0, 3);
            tx_ready = 1'b0;
            repeat (st) begin
                check("stall_txv", tx_valid, 1);
                check("stall_txd", tx_data, eb);
                step();
            end
            check("tx_valid", tx_valid, 1);
            check("tx_byte", tx_data, eb);
            tx_ready = 1'b1;
            step();
            tx_ready = 1'b0;
            if (rst_mid && k == 0) begin
                rstn = 1'b0;
                #1;
                exp_ovr = 1'b0;
                exp_to  = 1'b0;
                check_reset_outputs("rst_mid");
                step();
                rstn = 1'b1;
                step();
                return;
            end
        end
        check("end_txv", tx_valid, 0);
        check("end_busy", busy, 0);
        check("sticky_ovr", overrun, exp_ovr);
        check("sticky_to", timeout_err, exp_to);
    endtask

    initial begin
        repeat (3) step();
        check_reset_outputs("reset");
        rstn = 1'b1;
        step();

        mvm_done = 1'b1;
        mvm_y    = W_BUS_Y'($urandom);
        step();
        mvm_done = 1'b0;
        check("late_done_busy", busy, 0);
        check("late_done_txv", tx_valid, 0);

        run_frame(1'b1, 1'b0, 1'b0, 5);

        send_byte(8'hAA);
        repeat (10) step();
        check("to_early", timeout_err, 0);
        repeat (15) step();
        exp_to = 1'b1;
        check("to_set", timeout_err, 1);
        check("to_busy", busy, 0);
        run_frame(1'b0, 1'b0, 1'b0, -1);

        run_frame(1'b0, 1'b1, 1'b0, -1);
        run_frame(1'b0, 1'b0, 1'b1, -1);
        run_frame(1'b0, 1'b0, 1'b0, -1);

        for (int n = 0; n < 8; n++) begin
            run_frame(1'b0, 1'($urandom_range(0, 1)), 1'b0, -1);
        end

        step();
        check("start_count", n_starts, exp_starts);
        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
